// File: rtl/stove_pkg.sv
// Shared definitions for the stove front-panel input blocks: button FSM
// state encoding, default button timing and the hold-counter width.
package stove_pkg;

  typedef enum logic [1:0] {
    BTN_IDLE   = 2'd0,
    BTN_HELD   = 2'd1,
    BTN_REPEAT = 2'd2
  } btn_state_e;

  localparam int unsigned LONG_PRESS_DFLT    = 32'd50_000_000;
  localparam int unsigned REPEAT_PERIOD_DFLT = 32'd10_000_000;
  localparam int unsigned CNT_W              = 32'd32;

endpackage

// File: rtl/stove_sync2.sv
// Generic two-flop synchronizer for single-bit asynchronous inputs.
// The output is the second stage, which resets to 0.
module stove_sync2 (
  input  logic clk,
  input  logic async_nreset,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  // Shift the asynchronous input through two flops.
  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/stove_button_handler.sv
// Turns one debounced stove push-button into press, release, long-press and
// auto-repeat events, driven by the debouncer's stable strobe.
module stove_button_handler
  import stove_pkg::*;
#(
  parameter int unsigned LONG_PRESS    = LONG_PRESS_DFLT,
  parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_DFLT
) (
  input  logic clk,
  input  logic async_nreset,
  input  logic button_raw,
  input  logic stable_strobe,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic long_press,
  output logic pressed
);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_PRESS - 32'd1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_PERIOD - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic             level_s;
  btn_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             press_q;
  logic             release_q;
  logic             repeat_q;
  logic             long_q;
  logic             pressed_q;

  stove_sync2 u_sync (
    .clk          (clk),
    .async_nreset (async_nreset),
    .d_i          (button_raw),
    .q_o          (level_s)
  );

  // Button FSM and hold counter; a release strobe outranks the hold-time events.
  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      state_q   <= BTN_IDLE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
      long_q    <= 1'b0;
      pressed_q <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
      case (state_q)
        BTN_IDLE: begin
          if (stable_strobe && level_s) begin
            state_q   <= BTN_HELD;
            cnt_q     <= '0;
            press_q   <= 1'b1;
            pressed_q <= 1'b1;
          end else begin
            cnt_q <= '0;
          end
        end
        BTN_HELD, BTN_REPEAT: begin
          if (stable_strobe && !level_s) begin
            state_q   <= BTN_IDLE;
            cnt_q     <= '0;
            release_q <= 1'b1;
            pressed_q <= 1'b0;
            long_q    <= 1'b0;
          end else if ((state_q == BTN_HELD) && (cnt_q == LONG_LAST)) begin
            state_q  <= BTN_REPEAT;
            cnt_q    <= '0;
            long_q   <= 1'b1;
            repeat_q <= 1'b1;
          end else if ((state_q == BTN_REPEAT) && (cnt_q == REPEAT_LAST)) begin
            cnt_q    <= '0;
            repeat_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q   <= BTN_IDLE;
          cnt_q     <= '0;
          long_q    <= 1'b0;
          pressed_q <= 1'b0;
        end
      endcase
    end
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign repeat_pulse  = repeat_q;
  assign long_press    = long_q;
  assign pressed       = pressed_q;

endmodule

// File: tb/tb_stove_button_handler.sv
// Directed bench for stove_button_handler with LONG_PRESS=8, REPEAT_PERIOD=4.
// Expected output word order: {press, release, repeat, long_press, pressed}.
module tb_stove_button_handler;

  logic clk = 1'b0;
  logic async_nreset;
  logic button_raw;
  logic stable_strobe;
  logic press_pulse;
  logic release_pulse;
  logic repeat_pulse;
  logic long_press;
  logic pressed;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       raw;
    logic       stb;
    logic [4:0] exp;
    string      tag;
  } vec_t;

  vec_t vecs[$];

  stove_button_handler #(
    .LONG_PRESS    (8),
    .REPEAT_PERIOD (4)
  ) dut (
    .clk           (clk),
    .async_nreset  (async_nreset),
    .button_raw    (button_raw),
    .stable_strobe (stable_strobe),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .repeat_pulse  (repeat_pulse),
    .long_press    (long_press),
    .pressed       (pressed)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] outs();
    return {press_pulse, release_pulse, repeat_pulse, long_press, pressed};
  endfunction

  task automatic check(input logic [4:0] exp, input string tag);
    total++;
    if (outs() !== exp) begin
      bad++;
      $display("FAIL %s: got p/r/rep/long/pr=%b expected %b", tag, outs(), exp);
    end
  endtask

  // Drive inputs just after an edge, let the next edge sample them, check #1 later.
  task automatic step(input logic raw, input logic stb, input logic [4:0] exp, input string tag);
    button_raw    = raw;
    stable_strobe = stb;
    @(posedge clk);
    #1;
    check(exp, tag);
  endtask

  task automatic add(input logic raw, input logic stb, input logic [4:0] exp, input string tag);
    vec_t v;
    v.raw = raw;
    v.stb = stb;
    v.exp = exp;
    v.tag = tag;
    vecs.push_back(v);
  endtask

  // Hold for 20 cycles past the press; release strobe lands on a repeat boundary.
  task automatic add_hold(input string tag, input logic redundant);
    logic rp;
    logic lp;
    for (int i = 0; i < 3; i++) add(1'b1, 1'b0, 5'b00000, $sformatf("%s_pre%0d", tag, i));
    add(1'b1, 1'b1, 5'b10001, $sformatf("%s_press", tag));
    for (int k = 1; k <= 20; k++) begin
      rp = (k >= 8) && (((k - 8) % 4) == 0);
      lp = (k >= 8);
      add(1'b1, redundant && ((k % 3) == 0), {2'b00, rp, lp, 1'b1}, $sformatf("%s_off%0d", tag, k));
    end
    for (int k = 21; k <= 23; k++) add(1'b0, 1'b0, 5'b00011, $sformatf("%s_off%0d", tag, k));
    add(1'b0, 1'b1, 5'b01000, $sformatf("%s_release", tag));
    for (int i = 0; i < 2; i++) add(1'b0, 1'b0, 5'b00000, $sformatf("%s_post%0d", tag, i));
  endtask

  initial begin
    async_nreset  = 1'b1;
    button_raw    = 1'b0;
    stable_strobe = 1'b0;
    #2 async_nreset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check(5'b00000, "reset_state");
    async_nreset = 1'b1;

    // Short press
    for (int i = 0; i < 5; i++) add(1'b1, 1'b0, 5'b00000, $sformatf("short_pre%0d", i));
    add(1'b1, 1'b1, 5'b10001, "short_press");
    for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 5'b00001, $sformatf("short_hold%0d", i));
    add(1'b0, 1'b1, 5'b01000, "short_release");
    for (int i = 0; i < 2; i++) add(1'b0, 1'b0, 5'b00000, $sformatf("short_post%0d", i));

    add_hold("long", 1'b0);
    add_hold("redund", 1'b1);

    // Release strobe sampled while cnt==7 in HELD
    for (int i = 0; i < 3; i++) add(1'b1, 1'b0, 5'b00000, $sformatf("edge_pre%0d", i));
    add(1'b1, 1'b1, 5'b10001, "edge_press");
    for (int k = 1; k <= 4; k++) add(1'b1, 1'b0, 5'b00001, $sformatf("edge_off%0d", k));
    for (int k = 5; k <= 7; k++) add(1'b0, 1'b0, 5'b00001, $sformatf("edge_off%0d", k));
    add(1'b0, 1'b1, 5'b01000, "edge_release_cnt7");
    for (int k = 9; k <= 16; k++) add(1'b0, 1'b0, 5'b00000, $sformatf("edge_idle%0d", k));

    // Glitches without strobe
    for (int i = 0; i < 8; i++) add(i[0], 1'b0, 5'b00000, $sformatf("glitch%0d", i));

    for (int i = 0; i < vecs.size(); i++) step(vecs[i].raw, vecs[i].stb, vecs[i].exp, vecs[i].tag);

    // Reset mid-REPEAT, asserted between clock edges
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 5'b00000, "rst_pre");
    step(1'b1, 1'b1, 5'b10001, "rst_press");
    for (int k = 1; k <= 10; k++)
      step(1'b1, 1'b0, {2'b00, (k == 8), (k >= 8), 1'b1}, $sformatf("rst_off%0d", k));
    #3 async_nreset = 1'b0;
    #1;
    check(5'b00000, "rst_immediate");
    @(posedge clk);
    #1;
    check(5'b00000, "rst_held");
    #2 async_nreset = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 5'b00000, $sformatf("rst_nostrobe%0d", i));
    step(1'b1, 1'b1, 5'b10001, "rst_repress");
    step(1'b0, 1'b0, 5'b00001, "rst_hold");
    step(1'b0, 1'b0, 5'b00001, "rst_hold2");
    step(1'b0, 1'b1, 5'b01000, "rst_release");
    step(1'b0, 1'b0, 5'b00000, "rst_post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
